riscv_decode_stage: RTL and testbench

RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

---
 rtl/riscv_constants.sv | 42 ++++
 rtl/riscv_regfile.sv | 55 +++++
 rtl/riscv_decode_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared decode constants for the RV32I decode stage.
//   exec_fun_e : ALU operation handed to execute (ALU_ADD, ALU_X)
//   state_e    : decode-stage run state (RUN, HALT)
//   OPC_*/F3_*/F7_* : opcode and function-field encodings recognised by decode
//   imm_i/imm_b/imm_u : 32-bit immediate extraction from a raw instruction
package riscv_constants;

  typedef enum logic [0:0] {
    ALU_ADD = 1'b0,
    ALU_X   = 1'b1
  } exec_fun_e;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  // I-type immediate, sign-extended to 32 bits.
  function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  // B-type immediate, sign-extended to 32 bits; bit 0 is always zero.
  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // U-type immediate: upper 20 bits, low 12 bits zero.
  function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32 x WORD_LENGTH integer register file with two read ports and one write port.
//   clk, rst_n           : clock, asynchronous active-low reset (clears all registers)
//   rs1_addr/rs1_data    : read port 1 (combinational)
//   rs2_addr/rs2_data    : read port 2 (combinational)
//   wb_en/wb_addr/wb_data: write port, committed on the rising edge
// x0 always reads zero and ignores writes. A read of the register being
// written in the same cycle returns the incoming write data.
module riscv_regfile #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  output logic [WORD_LENGTH-1:0] rs1_data,
  output logic [WORD_LENGTH-1:0] rs2_data,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [WORD_LENGTH-1:0] wb_data
);

  logic [WORD_LENGTH-1:0] regs_q [32];
  logic [WORD_LENGTH-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_addr != 5'd0)) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [WORD_LENGTH-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end else if (wb_en && (wb_addr == addr)) begin
      return wb_data;
    end else begin
      return regs_q[addr];
    end
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage (ADD, ADDI, LUI, BEQ) with a one-entry output register.
//   if_valid/if_ready, if_pc, if_inst : instruction from fetch (valid/ready)
//   ex_valid/ex_ready                 : decoded bundle toward execute (valid/ready)
//   ex_pc, ex_data1, ex_data2, ex_imm : PC, ALU operands, branch offset
//   ex_exec_fun, ex_rd, ex_wb_en, ex_br : ALU op, destination, writeback enable, BEQ flag
//   flush                             : drop the held bundle (and any bundle loading now)
//   wb_en/wb_addr/wb_data             : register-file writeback port
//   halted                            : set once an illegal instruction has been accepted
module riscv_decode_stage
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [WORD_LENGTH-1:0] if_pc,
  input  logic [WORD_LENGTH-1:0] if_inst,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [WORD_LENGTH-1:0] ex_pc,
  output logic [WORD_LENGTH-1:0] ex_data1,
  output logic [WORD_LENGTH-1:0] ex_data2,
  output logic [WORD_LENGTH-1:0] ex_imm,
  output exec_fun_e              ex_exec_fun,
  output logic [4:0]             ex_rd,
  output logic                   ex_wb_en,
  output logic                   ex_br,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [WORD_LENGTH-1:0] wb_data,
  output logic                   halted
);

  // Widen a 32-bit signed immediate to the datapath width by sign extension.
  function automatic logic [WORD_LENGTH-1:0] sext32(input logic signed [31:0] v);
    return WORD_LENGTH'(v);
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;

  assign inst   = if_inst[31:0];
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  logic [WORD_LENGTH-1:0] rs1_data, rs2_data;

  riscv_regfile #(.WORD_LENGTH(WORD_LENGTH)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  // ---- Decode (combinational, from the presented instruction) ----
  exec_fun_e              dec_fun;
  logic [WORD_LENGTH-1:0] dec_data1, dec_data2, dec_imm;
  logic [4:0]             dec_rd;
  logic                   dec_wb_en, dec_br, dec_illegal;

  always_comb begin
    dec_fun     = ALU_X;
    dec_data1   = '0;
    dec_data2   = '0;
    dec_imm     = '0;
    dec_rd      = '0;
    dec_wb_en   = 1'b0;
    dec_br      = 1'b0;
    dec_illegal = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        if ((funct3 == F3_ADD) && (funct7 == F7_ADD)) begin
          dec_fun     = ALU_ADD;
          dec_data1   = rs1_data;
          dec_data2   = rs2_data;
          dec_rd      = rd;
          dec_wb_en   = 1'b1;
          dec_illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD) begin
          dec_fun     = ALU_ADD;
          dec_data1   = rs1_data;
          dec_data2   = sext32(imm_i(inst));
          dec_rd      = rd;
          dec_wb_en   = 1'b1;
          dec_illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_fun     = ALU_ADD;
        dec_data2   = sext32(imm_u(inst));
        dec_rd      = rd;
        dec_wb_en   = 1'b1;
        dec_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          // Execute compares the operands; the offset rides along in ex_imm.
          dec_fun     = ALU_ADD;
          dec_data1   = rs1_data;
          dec_data2   = rs2_data;
          dec_imm     = sext32(imm_b(inst));
          dec_br      = 1'b1;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---- Handshake and output register ----
  state_e                 state_q, state_d;
  logic                   halted_q;
  logic                   ex_valid_q, ex_valid_d;
  logic [WORD_LENGTH-1:0] ex_pc_q, ex_pc_d;
  logic [WORD_LENGTH-1:0] ex_data1_q, ex_data1_d;
  logic [WORD_LENGTH-1:0] ex_data2_q, ex_data2_d;
  logic [WORD_LENGTH-1:0] ex_imm_q, ex_imm_d;
  exec_fun_e              ex_fun_q, ex_fun_d;
  logic [4:0]             ex_rd_q, ex_rd_d;
  logic                   ex_wb_en_q, ex_wb_en_d;
  logic                   ex_br_q, ex_br_d;
  logic                   load;

  assign if_ready = (state_q == RUN) && (!ex_valid_q || ex_ready);
  assign load     = if_valid && if_ready;

  always_comb begin
    ex_pc_d    = ex_pc_q;
    ex_data1_d = ex_data1_q;
    ex_data2_d = ex_data2_q;
    ex_imm_d   = ex_imm_q;
    ex_fun_d   = ex_fun_q;
    ex_rd_d    = ex_rd_q;
    ex_wb_en_d = ex_wb_en_q;
    ex_br_d    = ex_br_q;
    if (load) begin
      ex_pc_d    = if_pc;
      ex_data1_d = dec_data1;
      ex_data2_d = dec_data2;
      ex_imm_d   = dec_imm;
      ex_fun_d   = dec_fun;
      ex_rd_d    = dec_rd;
      ex_wb_en_d = dec_wb_en;
      ex_br_d    = dec_br;
    end

    // Flush wins over a simultaneous load; the loaded fields are simply unused.
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (load) begin
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end

    // An illegal instruction that is flushed in the same cycle never halts.
    state_d = state_q;
    if (load && dec_illegal && !flush) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_data1_q <= '0;
      ex_data2_q <= '0;
      ex_imm_q   <= '0;
      ex_fun_q   <= ALU_X;
      ex_rd_q    <= '0;
      ex_wb_en_q <= 1'b0;
      ex_br_q    <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_data1_q <= ex_data1_d;
      ex_data2_q <= ex_data2_d;
      ex_imm_q   <= ex_imm_d;
      ex_fun_q   <= ex_fun_d;
      ex_rd_q    <= ex_rd_d;
      ex_wb_en_q <= ex_wb_en_d;
      ex_br_q    <= ex_br_d;
    end
  end

  // RUN/HALT state machine; HALT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_data1    = ex_data1_q;
  assign ex_data2    = ex_data2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_exec_fun = ex_fun_q;
  assign ex_rd       = ex_rd_q;
  assign ex_wb_en    = ex_wb_en_q;
  assign ex_br       = ex_br_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: the driver pushes a hand-computed
// expected bundle for every accepted instruction; the monitor pops and compares
// whenever execute takes a bundle (ex_valid && ex_ready).
module tb_riscv_decode_stage;
  import riscv_constants::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_inst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
  exec_fun_e   ex_exec_fun;
  logic [4:0]  ex_rd;
  logic        ex_wb_en, ex_br;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halted;

  riscv_decode_stage #(.WORD_LENGTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_pc       (ex_pc),
    .ex_data1    (ex_data1),
    .ex_data2    (ex_data2),
    .ex_imm      (ex_imm),
    .ex_exec_fun (ex_exec_fun),
    .ex_rd       (ex_rd),
    .ex_wb_en    (ex_wb_en),
    .ex_br       (ex_br),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    exec_fun_e   fun;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input exec_fun_e f, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input logic [4:0] rd, input logic wb,
                              input logic br);
    exp_t e;
    e.fun = f; e.pc = '0; e.d1 = d1; e.d2 = d2; e.imm = imm; e.rd = rd; e.wb = wb; e.br = br;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every bundle taken by execute is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL bundle_unexpected: got pc=0x%0h with no expectation queued", ex_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ex_exec_fun !== e.fun || ex_pc !== e.pc || ex_data1 !== e.d1 || ex_data2 !== e.d2 ||
            ex_imm !== e.imm || ex_rd !== e.rd || ex_wb_en !== e.wb || ex_br !== e.br) begin
          n_err++;
          $display("FAIL bundle pc=0x%0h: got fun=%0d d1=0x%0h d2=0x%0h imm=0x%0h rd=%0d wb=%0b br=%0b, required fun=%0d pc=0x%0h d1=0x%0h d2=0x%0h imm=0x%0h rd=%0d wb=%0b br=%0b",
                   ex_pc, ex_exec_fun, ex_data1, ex_data2, ex_imm, ex_rd, ex_wb_en, ex_br,
                   e.fun, e.pc, e.d1, e.d2, e.imm, e.rd, e.wb, e.br);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 one full cycle after the load.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e,
                       input bit push, input bit fl = 1'b0, input bit wbe = 1'b0,
                       input logic [4:0] wa = 5'd0, input logic [31:0] wd = 32'd0);
    int   cnt;
    exp_t ee;
    if_valid = 1'b1; if_pc = pc; if_inst = inst; flush = fl;
    wb_en = wbe; wb_addr = wa; wb_data = wd;
    cnt = 0;
    @(negedge clk);
    while (!if_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    if (!if_ready) begin
      chk("issue_timeout", {31'b0, if_ready}, 32'd1);
    end else if (push) begin
      ee = e; ee.pc = pc;
      q.push_back(ee);
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    chk("load_latency", {31'b0, ex_valid}, {31'b0, !fl});
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; ex_ready = 1'b1;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset values
    @(negedge clk);
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
    chk("rst_halted",   {31'b0, halted}, 32'd0);
    chk("rst_fun",      32'(ex_exec_fun), 32'(ALU_X));
    chk("rst_pc",       ex_pc, 32'd0);
    chk("rst_data1",    ex_data1, 32'd0);
    chk("rst_data2",    ex_data2, 32'd0);
    chk("rst_imm",      ex_imm, 32'd0);
    chk("rst_rd",       {27'b0, ex_rd}, 32'd0);
    chk("rst_wb_br",    {30'b0, ex_wb_en, ex_br}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);

    // ADD x3,x1,x2 ; ADDI x4,x0,-1 ; LUI x5,0x12345
    issue(32'h100, 32'h002081B3, mk(ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0), 1'b1);
    issue(32'h104, 32'hFFF00213, mk(ALU_ADD, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd4, 1'b1, 1'b0), 1'b1);
    issue(32'h108, 32'h123452B7, mk(ALU_ADD, 32'd0, 32'h12345000, 32'd0, 5'd5, 1'b1, 1'b0), 1'b1);

    // BEQ x1,x2,-8 stalled by execute for three cycles
    ex_ready = 1'b0;
    issue(32'h10C, 32'hFE208CE3, mk(ALU_ADD, 32'd5, 32'd7, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b1), 1'b1);
    if_valid = 1'b1; if_pc = 32'h110; if_inst = 32'h00500393;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_if_ready", {31'b0, if_ready}, 32'd0);
      chk("stall_ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("stall_pc",       ex_pc, 32'h10C);
      chk("stall_imm",      ex_imm, 32'hFFFFFFF8);
      chk("stall_br",       {31'b0, ex_br}, 32'd1);
      chk("stall_data1",    ex_data1, 32'd5);
    end
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    // ADDI x7,x0,5 loads as soon as the branch is taken by execute
    issue(32'h110, 32'h00500393, mk(ALU_ADD, 32'd0, 32'd5, 32'd0, 5'd7, 1'b1, 1'b0), 1'b1);

    // ADD x8,x6,x0 with x6 written in the same cycle (bypass)
    issue(32'h114, 32'h00030433, mk(ALU_ADD, 32'hAA, 32'd0, 32'd0, 5'd8, 1'b1, 1'b0), 1'b1,
          1'b0, 1'b1, 5'd6, 32'hAA);
    // ADD x9,x0,x0 while x0 is being written: x0 still reads zero
    issue(32'h118, 32'h000004B3, mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0), 1'b1,
          1'b0, 1'b1, 5'd0, 32'h55);
    // ADD x10,x6,x6: x6 was committed
    issue(32'h11C, 32'h00630533, mk(ALU_ADD, 32'hAA, 32'hAA, 32'd0, 5'd10, 1'b1, 1'b0), 1'b1);

    // Flush on the load cycle drops the bundle
    issue(32'h120, 32'h00100593, mk(ALU_ADD, 32'd0, 32'd1, 32'd0, 5'd11, 1'b1, 1'b0), 1'b0, 1'b1);
    // Flushed illegal instruction does not halt
    issue(32'h124, 32'h00000000, mk(ALU_X, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_ill_halted",   {31'b0, halted}, 32'd0);
    chk("flush_ill_if_ready", {31'b0, if_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Illegal instruction halts the stage; bundle still drains
    issue(32'h128, 32'h00000000, mk(ALU_X, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0), 1'b1);
    if_valid = 1'b1; if_pc = 32'h12C; if_inst = 32'h00500393;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_halted",   {31'b0, halted}, 32'd1);
      chk("halt_if_ready", {31'b0, if_ready}, 32'd0);
      chk("halt_ex_valid", {31'b0, ex_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;

    // Reset clears HALT
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-stall discards the held bundle
    ex_ready = 1'b0;
    issue(32'h200, 32'h002081B3, mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0), 1'b0);
    @(negedge clk);
    chk("midstall_held", {31'b0, ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_if_ready", {31'b0, if_ready}, 32'd1);
    chk("post_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    @(posedge clk);
    #1;
    // Registers were cleared by reset: ADD x3,x1,x2 reads zeros
    issue(32'h204, 32'h002081B3, mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0), 1'b1);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
